// File: rtl/mage_pkg.sv
// Shared MAGE definitions: the global execution state seen by every PE-side unit.
// Only the EXEC encoding matters to the accumulation writeback.
package mage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONF = 2'd1,
        ST_EXEC = 2'd2,
        ST_HALT = 2'd3
    } state_t;

endpackage

// File: rtl/accumulation_writeback.sv
// accumulation_writeback: captures the PE accumulator on each accumulation-end
// rising edge, clears the accumulator, buffers results and streams them out.
// Ports: clk_i/rst_n_i (async active-low), state_i (global state), acc_end_i,
// acc_data_i, reg_n_out_i (results per kernel, 0 = unbounded), acc_clear_o,
// out_valid_o/out_ready_i/out_data_o/out_last_o, overflow_o (sticky), done_o.
// Optional macro ACC_WB_SHIFT_EN adds reg_shift_i: rounded, saturated
// arithmetic right shift of the captured value.
module accumulation_writeback
    import mage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  state_t                    state_i,
    input  logic                      acc_end_i,
    input  logic [DATA_W-1:0]         acc_data_i,
    input  logic [CNT_W-1:0]          reg_n_out_i,
`ifdef ACC_WB_SHIFT_EN
    input  logic [$clog2(DATA_W)-1:0] reg_shift_i,
`endif
    output logic                      acc_clear_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_W-1:0]         out_data_o,
    output logic                      out_last_o,
    output logic                      overflow_o,
    output logic                      done_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_t;

    fsm_t              fsm_q;
    logic              acc_end_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
    logic              ovf_q, ovf_d;
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
    logic              last_mem_q [FIFO_DEPTH];

    logic              exec, evt, start;
    logic              empty, full, push, pop, last;
    logic [DATA_W-1:0] wdata;

    assign exec  = (state_i == ST_EXEC);
    assign evt   = acc_end_i & ~acc_end_q & exec;
    assign start = (fsm_q == IDLE) & exec;
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign pop   = ~empty & out_ready_i;
    // A full buffer still accepts a result when the head leaves this cycle.
    assign push  = evt & (~full | pop);

    // The kernel-start clear applies to the same cycle's event.
    assign cnt_base = start ? '0 : cnt_q;
    assign last = (reg_n_out_i != '0) &&
                  (cnt_base == reg_n_out_i - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_base;
        ovf_d = start ? 1'b0 : ovf_q;
        if (evt) begin
            cnt_d = last ? '0 : cnt_base + CNT_W'(1);
            if (full & ~pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    assign count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

`ifdef ACC_WB_SHIFT_EN
    localparam int SW = $clog2(DATA_W);
    logic signed [DATA_W:0] ext, rnd, sum, shr;

    always_comb begin
        ext = {acc_data_i[DATA_W-1], acc_data_i};
        rnd = '0;
        if (reg_shift_i != '0) begin
            rnd[reg_shift_i - SW'(1)] = 1'b1;
        end
        sum = ext + rnd;
        shr = sum >>> reg_shift_i;
        wdata = shr[DATA_W-1:0];
        // Top two bits disagree: value left the signed DATA_W range.
        if (shr[DATA_W] != shr[DATA_W-1]) begin
            wdata = shr[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign wdata = acc_data_i;
`endif

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem_q[wr_q] <= wdata;
            last_mem_q[wr_q] <= last;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fsm_q     <= IDLE;
            acc_end_q <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
        end else begin
            acc_end_q <= acc_end_i;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case (fsm_q)
                IDLE: begin
                    if (exec) begin
                        fsm_q <= RUN;
                    end
                end
                RUN: begin
                    if (!exec) begin
                        fsm_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Re-entering EXEC resumes the kernel, even when empty.
                    if (exec) begin
                        fsm_q <= RUN;
                    end else if (empty) begin
                        fsm_q <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign acc_clear_o = evt;
    assign out_valid_o = ~empty;
    assign out_data_o  = data_mem_q[rd_q];
    assign out_last_o  = last_mem_q[rd_q];
    assign overflow_o  = ovf_q;
    assign done_o      = (fsm_q == DRAIN) & empty & ~exec;

endmodule

// File: doc/accumulation_writeback.md
Name: accumulation_writeback

Overview:
- Consumer side of the accumulation-counter end interface.
- Detects each accumulation-complete event, captures the PE accumulator value, and issues a one-cycle accumulator clear.
- Buffers captured results in a small FIFO and streams them out over a valid/ready interface towards the output stream / memory writer.
- Sits in the execute stage next to the accumulation counter, one instance per accumulating PE output.

Parameters:
- DATA_W, 32, width of accumulator value and output data.
- FIFO_DEPTH, 4, result buffer entries; power of two, >= 2.
- CNT_W, 16, width of the result counter and the reg_n_out_i register.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- state_i  in  state_t  global MAGE state; capture is enabled only in EXEC.
- acc_end_i  in  1  end level from the accumulation counter; high while the trip count is reached.
- acc_data_i  in  DATA_W  current accumulator value.
- reg_n_out_i  in  CNT_W  number of results per kernel; 0 means unbounded (no last).
- acc_clear_o  out  1  one-cycle pulse that clears the accumulator.
- out_valid_o  out  1  output data valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  DATA_W  result at the FIFO head.
- out_last_o  out  1  head entry is the final result of the kernel.
- overflow_o  out  1  sticky; a result was dropped.
- done_o  out  1  one-cycle pulse when the drain completes.

Behaviour:
- Reset values: all outputs 0; FIFO empty; result counter 0; FSM in IDLE; edge register 0.
- Event detection:
  - acc_end_i is a level that can stay high for many cycles.
  - event = acc_end_i & ~acc_end_q & (state_i == EXEC), where acc_end_q is acc_end_i registered.
  - Exactly one capture per rising edge.
- Capture, in the event cycle:
  - acc_data_i and the last flag are written into the FIFO.
  - acc_clear_o is high for that same cycle only.
  - Data appears at out_data_o/out_valid_o no earlier than the next cycle (1-cycle latency when empty).
- Last flag and result counter:
  - last = (reg_n_out_i != 0) && (result counter == reg_n_out_i-1).
  - The counter increments on each event and wraps to 0 after a last.
- Handshake:
  - Pop occurs when out_valid_o & out_ready_i.
  - out_valid_o = FIFO not empty.
  - out_data_o and out_last_o are stable while valid && !ready.
- Boundary conditions:
  - FIFO full with an event and no pop in the same cycle: entry dropped, overflow_o set, counter still advances, acc_clear_o still pulses.
  - Full with push and pop in the same cycle: both take effect, occupancy unchanged, no overflow.
  - Empty with an event: push only; there is no same-cycle bypass.
- FSM:
  - IDLE -> RUN when state_i == EXEC; overflow_o and the result counter are cleared on this transition.
  - RUN -> DRAIN when state_i != EXEC. An event cannot occur in this cycle: the event term requires EXEC.
  - DRAIN -> IDLE when the FIFO is empty; done_o pulses one cycle on this transition.
  - DRAIN with state_i back in EXEC before empty: go to RUN without done_o and without clearing the counter or overflow.
- Reset mid-operation: the FIFO is flushed immediately, the FSM returns to IDLE, and no done_o is issued.

Optional Feature:
- Macro: ACC_WB_SHIFT_EN.
- Defined:
  - Adds input port reg_shift_i [$clog2(DATA_W)-1:0].
  - The captured value is acc_data_i arithmetically right-shifted by reg_shift_i, with round-half-up: add 1<<(shift-1) before the shift when shift>0.
  - Result is saturated to the signed DATA_W range.
  - Capture latency is unchanged; the shift is combinational before the FIFO write.
- Undefined: the port is absent and data is stored unmodified.

Test Plan:
- Single event, out_ready_i=1, reg_n_out_i=1:
  - Stimulus: acc_end_i held high 5 cycles with acc_data_i=0x1234.
  - Response: exactly one acc_clear_o pulse; one transfer of 0x1234 with out_last_o=1 one cycle later.
- Backpressure and overflow, FIFO_DEPTH=4, out_ready_i=0:
  - Stimulus: 5 events with values 1..5.
  - Response: FIFO holds 1..4; overflow_o=1 after the 5th event.
  - Then ready=1: outputs 1,2,3,4 in order, held stable while stalled.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, event with value 9 in the same cycle as a pop.
  - Response: no overflow; 9 is emitted after the remaining entries.
- Last flag, reg_n_out_i=3:
  - Stimulus: 6 events.
  - Response: out_last_o=1 on results 3 and 6 only.
- Drain:
  - Stimulus: 2 entries buffered, state_i leaves EXEC, ready=1.
  - Response: both entries emitted, then done_o pulses once; overflow_o cleared on the next EXEC entry.
- Async reset:
  - Stimulus: rst_n_i asserted mid-drain.
  - Response: out_valid_o=0 immediately; no done_o.
- With ACC_WB_SHIFT_EN:
  - Stimulus: acc_data_i=0x0000_0017, reg_shift_i=2.
  - Response: out_data_o=6.
